// File: rtl/seven_seg_multi_display.sv
// Multi-digit active-low 7-segment driver: hex or decimal (sequential double-dabble) display
// with leading-zero blanking, overflow dashes and blink.
//   state | meaning
//   IDLE  | display stable, load accepted
//   CONV  | double-dabble in progress, one bit per cycle, load ignored
module seven_seg_multi_display #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [DATA_W-1:0]       value,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    ovf,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int DW      = 4 * NUM_DIGITS;
  // ceil(DATA_W*log10(2)) + 1 nibbles, using 0.302 as a safe upper bound for log10(2)
  localparam int BCD_MIN = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int BW      = 4 * BCD_N;
  localparam int PW      = (DATA_W > DW) ? DATA_W : DW;
  localparam int CW      = $clog2(DATA_W + 1);
  localparam int BLW     = $clog2(BLINK_DIV);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [0:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_next;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     dig;
  logic              mode_hex;
  logic [PW-1:0]     val_pad;
  logic              ovf_dec;
  logic              ovf_hex;
  logic [BLW-1:0]    blink_cnt;
  logic              blink_ph;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  assign busy    = (state == CONV);
  assign val_pad = PW'(value);

  always_comb begin
    ovf_hex = 1'b0;
    for (int i = DW; i < PW; i++) ovf_hex = ovf_hex | val_pad[i];
  end

  // One double-dabble step: a nibble >= 5 gets +3, whose carry is exactly (nibble >= 5).
  always_comb begin : dabble
    logic       c;
    logic [3:0] nib;
    bcd_next = '0;
    nib      = '0;
    c        = shreg[DATA_W-1];
    for (int i = 0; i < BCD_N; i++) begin
      nib = bcd[4*i +: 4];
      bcd_next[4*i +: 4] = {(nib >= 4'd5) ? (nib[2:0] + 3'd3) : nib[2:0], c};
      c = (nib >= 4'd5);
    end
  end

  always_comb begin
    ovf_dec = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_N; i++)
      if (bcd_next[4*i +: 4] != 4'd0) ovf_dec = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      dig      <= '0;
      mode_hex <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            if (hex_mode) begin
              dig      <= val_pad[DW-1:0];
              ovf      <= ovf_hex;
              mode_hex <= 1'b1;
            end else begin
              shreg <= value;
              bcd   <= '0;
              cnt   <= CW'(DATA_W);
              state <= CONV;
            end
          end
        end
        CONV: begin
          shreg <= shreg << 1;
          bcd   <= bcd_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            dig      <= bcd_next[DW-1:0];
            ovf      <= ovf_dec;
            mode_hex <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + BLW'(1);
    end
  end

  // Scan from the top digit down; run stays high while every digit so far is zero.
  always_comb begin : render
    logic       run;
    logic [3:0] nib;
    logic [6:0] seg;
    HEX = '0;
    run = 1'b1;
    nib = '0;
    seg = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = dig[4*i +: 4];
      run = run & (nib == 4'd0);
      if (blink_en && blink_ph)          seg = SEG_BLANK;
      else if (ovf && !mode_hex)         seg = SEG_DASH;
      else if (blank_lz && run && i != 0) seg = SEG_BLANK;
      else                               seg = seg7(nib);
      HEX[7*i +: 7] = seg;
    end
  end

endmodule

// File: tb/tb_seven_seg_multi_display.sv
// Directed + randomized bench for seven_seg_multi_display against an arithmetic
// reference model (decimal digits by division, hex digits by nibble extraction).
module tb_seven_seg_multi_display;
  localparam int ND = 4;
  localparam int DW = 14;
  localparam int BD = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            load = 1'b0;
  logic [DW-1:0]   value = '0;
  logic            hex_mode = 1'b0;
  logic            blank_lz = 1'b0;
  logic            blink_en = 1'b0;
  logic            busy;
  logic            ovf;
  logic [7*ND-1:0] HEX;

  int          compared = 0;
  int          mismatched = 0;
  int          bcnt;
  int unsigned cur_v = 0;
  bit          cur_hx = 1'b0;
  logic [6:0]  tab [16];

  seven_seg_multi_display #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(BD)) dut (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .ovf(ovf), .HEX(HEX)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn)
    if (!resetn) bcnt <= 0;
    else         bcnt <= bcnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ovf(input int unsigned v, input bit hx);
    return hx ? (v > 32'hFFFF) : (v > 9999);
  endfunction

  function automatic logic [7*ND-1:0] model_hex(input int unsigned v, input bit hx, input bit lz,
                                                input bit ben, input bit hidden);
    int unsigned      d [ND];
    int unsigned      p;
    int               top;
    logic [7*ND-1:0]  r;
    p = 1; top = 0; r = '0;
    for (int i = 0; i < ND; i++) begin
      d[i] = hx ? ((v >> (4*i)) & 15) : ((v / p) % 10);
      p = p * 10;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < ND; i++) begin
      if (ben && hidden)                r[7*i +: 7] = 7'b1111111;
      else if (model_ovf(v, hx) && !hx) r[7*i +: 7] = 7'b0111111;
      else if (lz && i > top)           r[7*i +: 7] = 7'b1111111;
      else                              r[7*i +: 7] = tab[d[i]];
    end
    return r;
  endfunction

  task automatic check_display(input string tag);
    check(tag, HEX, model_hex(cur_v, cur_hx, blank_lz, blink_en, ((bcnt / BD) % 2) == 1));
    check({tag, "_ovf"}, ovf, model_ovf(cur_v, cur_hx));
  endtask

  task automatic do_load(input int unsigned v, input bit hx);
    int n;
    n = 0;
    value = DW'(v); hex_mode = hx; load = 1'b1;
    step();
    load = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("latency", n, hx ? 0 : DW);
    cur_v = v; cur_hx = hx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    bit          hx;
    tab[0]  = 7'b1000000; tab[1]  = 7'b1111001; tab[2]  = 7'b0100100; tab[3]  = 7'b0110000;
    tab[4]  = 7'b0011001; tab[5]  = 7'b0010010; tab[6]  = 7'b0000010; tab[7]  = 7'b1111000;
    tab[8]  = 7'b0000000; tab[9]  = 7'b0010000; tab[10] = 7'b0001000; tab[11] = 7'b0000011;
    tab[12] = 7'b1000110; tab[13] = 7'b0100001; tab[14] = 7'b0000110; tab[15] = 7'b0001110;

    #2;
    check("rst_hex", HEX, {ND{7'b1000000}});
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_display("post_rst");

    do_load(14'h2BEF, 1'b1);
    check("hex_2bef", HEX, {7'b0100100, 7'b0000011, 7'b0000110, 7'b0001110});
    check("hex_busy", busy, 1'b0);
    check("hex_ovf", ovf, 1'b0);

    value = 14'd1234; hex_mode = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    check("conv_busy_k", busy, 1'b1);
    check_display("conv_hold_k");
    for (int j = 1; j < DW; j++) begin
      if (j == 5) begin
        value = 14'd9; hex_mode = 1'b1; load = 1'b1;
      end
      step();
      load = 1'b0;
      check("conv_busy", busy, 1'b1);
      check_display("conv_hold");
    end
    step();
    check("conv_done_busy", busy, 1'b0);
    cur_v = 1234; cur_hx = 1'b0;
    check("dec_1234", HEX, {tab[1], tab[2], tab[3], tab[4]});
    check_display("dec_1234_model");

    do_load(16383, 1'b0);
    check("ovf_flag", ovf, 1'b1);
    check("ovf_dash", HEX, {ND{7'b0111111}});
    blank_lz = 1'b1;
    #1;
    check("ovf_dash_lz", HEX, {ND{7'b0111111}});

    do_load(7, 1'b0);
    check("lz_7", HEX, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
    do_load(0, 1'b0);
    check("lz_0", HEX, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    do_load(14'h00A0, 1'b1);
    check_display("lz_hex");
    blank_lz = 1'b0;
    #1;
    check_display("lz_off_live");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0:       v = 9999;
        1:       v = 10000;
        2:       v = $urandom_range(0, 99);
        default: v = $urandom_range(0, 16383);
      endcase
      hx = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      do_load(v, hx);
      check_display("rand");
      check("rand_busy", busy, 1'b0);
    end

    blank_lz = 1'b0;
    do_load(1234, 1'b0);
    blink_en = 1'b1;
    for (int j = 0; j < 4 * BD; j++) begin
      step();
      check_display("blink_on");
    end
    blink_en = 1'b0;
    for (int j = 0; j < 2 * BD; j++) begin
      step();
      check("blink_off", HEX, {tab[1], tab[2], tab[3], tab[4]});
    end

    value = 14'd1234; hex_mode = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    check("midrst_hex", HEX, {ND{7'b1000000}});
    cur_v = 0; cur_hx = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    step();
    check_display("after_midrst");
    do_load(42, 1'b0);
    check_display("after_midrst_load");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
